// File: rtl/morty_clint.sv
// rtl/morty_clint.sv - machine timer / software interrupt source (mtime, mtimecmp, msip) on a Wishbone-classic slave
// Optional mtime prescaler enabled by defining MORTY_CLINT_PRESCALER_EN.
module morty_clint #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        int_mtip_o,
    output logic        int_msip_o
);
    localparam logic [2:0] ADDR_MSIP     = 3'd0;
    localparam logic [2:0] ADDR_MTCMP_LO = 3'd1;
    localparam logic [2:0] ADDR_MTCMP_HI = 3'd2;
    localparam logic [2:0] ADDR_MTIME_LO = 3'd3;
    localparam logic [2:0] ADDR_MTIME_HI = 3'd4;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        ack_q, err_q;
    logic        mtip_q, msip_out_q;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  word;
    logic        req, mapped, wr, wr_mtime, tick;
    logic        unused_adr;

    assign word       = wb_adr_i[4:2];
    assign unused_adr = ^wb_adr_i[1:0];
    // A held strobe is masked while ack/err is up, so each access is served once.
    assign req      = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    assign mapped   = (word <= ADDR_MTIME_HI);
    assign wr       = req & mapped & wb_we_i;
    assign wr_mtime = wr & ((word == ADDR_MTIME_LO) | (word == ADDR_MTIME_HI));

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] dat,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = dat[8*b +: 8];
        end
        return res;
    endfunction

`ifdef MORTY_CLINT_PRESCALER_EN
    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);
    logic [15:0] div_q, div_d;

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        div_d = tick ? 16'd0 : div_q + 16'd1;
        if (wr_mtime) div_d = 16'd0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) div_q <= 16'd0;
        else       div_q <= div_d;
    end
`else
    localparam int unsigned unused_tick_div = TICK_DIV;
    assign tick = 1'b1;
`endif

    always_comb begin
        rdata_d = 32'd0;
        case (word)
            ADDR_MSIP:     rdata_d = {31'd0, msip_q};
            ADDR_MTCMP_LO: rdata_d = mtimecmp_q[31:0];
            ADDR_MTCMP_HI: rdata_d = mtimecmp_q[63:32];
            ADDR_MTIME_LO: rdata_d = mtime_q[31:0];
            ADDR_MTIME_HI: rdata_d = mtime_q[63:32];
            default:       rdata_d = 32'd0;
        endcase
    end

    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        if (wr) begin
            case (word)
                ADDR_MSIP:     if (wb_sel_i[0]) msip_d = wb_dat_i[0];
                ADDR_MTCMP_LO: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], wb_dat_i, wb_sel_i);
                ADDR_MTCMP_HI: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wb_dat_i, wb_sel_i);
                // A bus write to mtime suppresses the increment for the whole 64 bits.
                ADDR_MTIME_LO: mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wb_dat_i, wb_sel_i)};
                ADDR_MTIME_HI: mtime_d = {merge_bytes(mtime_q[63:32], wb_dat_i, wb_sel_i), mtime_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= {64{1'b1}};
            msip_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
            mtip_q     <= 1'b0;
            msip_out_q <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            ack_q      <= req & mapped;
            err_q      <= req & ~mapped;
            rdata_q    <= (req & mapped) ? rdata_d : 32'd0;
            mtip_q     <= (mtime_q >= mtimecmp_q);
            msip_out_q <= msip_q;
        end
    end

    assign wb_dat_o   = rdata_q;
    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign int_mtip_o = mtip_q;
    assign int_msip_o = msip_out_q;
endmodule

// File: doc/morty_clint.md
# morty_clint

Machine-level timer and software-interrupt source for the XYZ core. It holds the 64-bit `mtime` counter, the `mtimecmp` compare register and the `msip` bit behind a Wishbone-classic slave port. It drives the `int_mtip`/`int_msip` lines that the writeback stage samples into `mip` and uses to take traps. It is the producer end of the interrupt lines the core consumes. `int_meip` is not generated here.

## Interface
- `TICK_DIV`, default 4: `mtime` increment period in `clk_i` cycles. Legal range 2..65535. Used only when `MORTY_CLINT_PRESCALER_EN` is defined.
- `clk_i` input, 1 bit: single clock; all state updates on its rising edge.
- `rst_i` input, 1 bit: reset, synchronous and active-high.
- `wb_cyc_i` input, 1 bit: bus cycle valid.
- `wb_stb_i` input, 1 bit: strobe.
- `wb_we_i` input, 1 bit: 1 = write, 0 = read.
- `wb_adr_i` input, 5 bits: byte address; bits [1:0] ignored.
- `wb_sel_i` input, 4 bits: byte enables for writes.
- `wb_dat_i` input, 32 bits: write data.
- `wb_dat_o` output, 32 bits: read data, valid only while `wb_ack_o` is high.
- `wb_ack_o` output, 1 bit: single-cycle acknowledge.
- `wb_err_o` output, 1 bit: single-cycle error for unmapped addresses.
- `int_mtip_o` output, 1 bit: timer interrupt pending, to the core's `int_mtip_wb_i`.
- `int_msip_o` output, 1 bit: software interrupt pending, to the core's `int_msip_wb_i`.

## Operation
- Register map (word offsets), all read/write:
  - 0x00: `msip`. Only bit 0 is implemented; other bits read 0.
  - 0x04: `mtimecmp[31:0]`.
  - 0x08: `mtimecmp[63:32]`.
  - 0x0C: `mtime[31:0]`.
  - 0x10: `mtime[63:32]`.
  - 0x14..0x1C are unmapped.
- Reset values:
  - `mtime` = 0.
  - `mtimecmp` = 0xFFFF_FFFF_FFFF_FFFF.
  - `msip` = 0.
  - Prescaler count = 0.
  - All outputs = 0.
- Bus handshake:
  - A request is `wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o`.
  - At the edge that samples a request, a mapped access commits its write and sets `wb_ack_o`. An unmapped access sets `wb_err_o` and makes no state change.
  - Ack and err clear unconditionally at the next edge. The slave therefore serves at most one access every 2 cycles, and a held strobe is never acknowledged twice in a row.
- Reads return the register value as it was before the acknowledging edge.
- Byte writes:
  - Each `wb_sel_i[n]` enables write data byte n.
  - For `msip`, only `sel[0]` and `dat[0]` matter.
- `mtime` counting:
  - `mtime` increments by 1 per tick, as one 64-bit add: low half 0xFFFF_FFFF carries into the high half, and 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
  - A bus write to either `mtime` half takes priority over the increment in the same cycle. The written half takes the written bytes; the other half holds, with no increment applied.
- Interrupt outputs, registered:
  - `int_mtip_o` <= (`mtime` >= `mtimecmp`), an unsigned 64-bit compare of the pre-edge values.
  - `int_msip_o` <= `msip`.
  - `int_mtip_o` stays level-high until `mtimecmp` is raised above `mtime` or `mtime` is written below it. There is no acknowledge path.
- Reset mid-access: `rst_i` dominates. Ack/err drop, any in-flight write is discarded and every register takes its reset value.

## Timing
- Read and write latency: ack or err is high during the cycle after the request edge. Write data is visible in the register from that same edge.
- `int_msip_o` and `int_mtip_o` change 1 cycle after the register update that causes them. Example: a write to `msip` acknowledged at edge k gives `int_msip_o` = 1 after edge k+1.
- The compare is against the current `mtime`. When `mtime` steps to equal `mtimecmp` at edge k, `int_mtip_o` rises at edge k+1.

## Configuration
- `MORTY_CLINT_PRESCALER_EN` defined:
  - A 16-bit divider counts 0..`TICK_DIV`-1.
  - `mtime` increments only on the cycle the divider wraps to 0, i.e. every `TICK_DIV` cycles.
  - A bus write to `mtime` resets the divider to 0.
- Not defined:
  - `mtime` increments every `clk_i` cycle.
  - No divider logic exists and `TICK_DIV` is ignored.

## Test plan
- Reset check: assert `rst_i` for 2 cycles, then immediately read 0x00/0x04/0x08 -> 0x0, 0xFFFFFFFF, 0xFFFFFFFF. Both interrupt outputs stay 0 throughout.
- Timer interrupt (macro off): write `mtime` = 0, `mtimecmp` hi = 0, lo = 0x20. `int_mtip_o` must rise exactly 1 cycle after `mtime` reaches 0x20. Then write `mtimecmp` lo = 0x1000 -> `int_mtip_o` = 0 one cycle after the ack.
- Software interrupt: write 0x00 = 0x1 -> `int_msip_o` = 1 one cycle after ack. Write 0xFFFFFFFE -> `int_msip_o` = 0. A readback after each write returns 0x1, then 0x0.
- Carry/wrap: write `mtime` lo = 0xFFFFFFFE, hi = 0x7. After 2 ticks, reading hi returns 0x8 and low ≤ 2.
- Byte enables: write `mtimecmp` lo = 0x000000AB with `sel` = 0001 -> readback 0xFFFFFFAB. An access to 0x14 -> `wb_err_o` pulses 1 cycle, `wb_ack_o` = 0, no register changes. A strobe held for 4 cycles gets exactly 2 ack pulses.
- Prescaler (macro on, `TICK_DIV` = 4): write `mtime` = 0, wait 12 cycles, read `mtime` lo -> 3. Assert `rst_i` during an acknowledged `msip` write -> `msip` reads back 0.
